// File: rtl/adder_share_arb.sv
// Two-requester round-robin front end for the shared 16-bit carry-lookahead add/sub unit.
// Requests are served one at a time: IDLE (grant) -> EXEC (compute) -> RESP (return result).
module adder_share_arb #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [15:0] r0_a,
    input  logic [15:0] r0_b,
    input  logic        r0_sub,
    input  logic        r0_sign,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [15:0] r0_sum,
    output logic        r0_ovf,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [15:0] r1_a,
    input  logic [15:0] r1_b,
    input  logic        r1_sub,
    input  logic        r1_sign,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [15:0] r1_sum,
    output logic        r1_ovf,
    output logic        busy,
    output logic        owner,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request/response transfers on a rising edge where valid and
    // ready are both high; valid never depends on ready, ready may depend on valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;
    logic        r_owner;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_sub;
    logic        r_sign;
    logic [15:0] r_sum;
    logic        r_ovf;

    logic        w_grant_id;
    logic        w_accept;
    logic        w_rsp_done;

    logic [15:0] w_b_eff;
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_sum;
    logic        w_cout;
    logic        w_ovf;
    logic        w_gg;
    logic        w_gp;
    logic        w_gc;
    logic        w_c;

    // Arbitration and FSM next state.
    always_comb begin
        w_grant_id = (r0_valid && r1_valid) ? r_ptr : r1_valid;
        w_accept   = (r_state == S_IDLE) && (r0_valid || r1_valid);
        w_rsp_done = (r_state == S_RESP) && (r_owner ? r1_rsp_ready : r0_rsp_ready);
        w_next     = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (w_rsp_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // 4x4-bit carry-lookahead: group generate/propagate choose each group carry-in,
    // bits inside a group resolve from that carry-in.
    always_comb begin
        w_b_eff = r_b ^ {16{r_sub}};
        w_g     = r_a & w_b_eff;
        w_p     = r_a ^ w_b_eff;
        w_sum   = '0;
        w_gc    = r_sub;
        w_c     = 1'b0;
        w_gg    = 1'b0;
        w_gp    = 1'b0;
        for (int j = 0; j < 4; j++) begin
            w_gg = w_g[4*j+3]
                 | (w_p[4*j+3] & w_g[4*j+2])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_gp = &w_p[4*j +: 4];
            w_c  = w_gc;
            for (int k = 0; k < 4; k++) begin
                w_sum[4*j+k] = w_p[4*j+k] ^ w_c;
                w_c          = w_g[4*j+k] | (w_p[4*j+k] & w_c);
            end
            w_gc = w_gg | (w_gp & w_gc);
        end
        w_cout = w_gc;
        w_ovf  = r_sign ? ((r_a[15] == w_b_eff[15]) && (w_sum[15] != r_a[15])) : w_cout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= RR_INIT;
            r_owner <= RR_INIT;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_sign  <= 1'b0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_grant_id;
                r_a     <= w_grant_id ? r1_a    : r0_a;
                r_b     <= w_grant_id ? r1_b    : r0_b;
                r_sub   <= w_grant_id ? r1_sub  : r0_sub;
                r_sign  <= w_grant_id ? r1_sign : r0_sign;
            end
            if (r_state == S_EXEC) begin
                r_sum <= w_sum;
                r_ovf <= w_ovf;
            end
            // Priority moves only when a response completes.
            if (w_rsp_done) begin
                r_ptr <= ~r_owner;
            end
        end
    end

    assign r0_ready     = w_accept && !w_grant_id;
    assign r1_ready     = w_accept && w_grant_id;
    assign r0_rsp_valid = (r_state == S_RESP) && !r_owner;
    assign r1_rsp_valid = (r_state == S_RESP) && r_owner;
    assign r0_sum       = r_sum;
    assign r1_sum       = r_sum;
    assign r0_ovf       = r_ovf;
    assign r1_ovf       = r_ovf;
    assign busy         = (r_state != S_IDLE);
    assign owner        = r_owner;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed + randomized bench for adder_share_arb; results are predicted with
// plain integer arithmetic and arbitration is predicted from a priority pointer.
module tb_adder_share_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  tb_valid;
    logic [15:0] tb_a [2];
    logic [15:0] tb_b [2];
    logic [1:0]  tb_sub;
    logic [1:0]  tb_sign;
    logic [1:0]  tb_rsp_ready;

    logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_ovf, r1_ovf;
    logic [15:0] r0_sum, r1_sum;
    logic        busy, owner;
    logic [1:0]  dbg_state;
    logic [1:0]  w_ready;
    logic [1:0]  w_rsp;

    int          n_checks;
    int          n_errors;
    bit          exp_ptr;
    logic [15:0] pend_a, pend_b;
    logic        pend_sub, pend_sign;

    adder_share_arb dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(tb_valid[0]), .r0_ready(r0_ready), .r0_a(tb_a[0]), .r0_b(tb_b[0]),
        .r0_sub(tb_sub[0]), .r0_sign(tb_sign[0]), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(tb_rsp_ready[0]), .r0_sum(r0_sum), .r0_ovf(r0_ovf),
        .r1_valid(tb_valid[1]), .r1_ready(r1_ready), .r1_a(tb_a[1]), .r1_b(tb_b[1]),
        .r1_sub(tb_sub[1]), .r1_sign(tb_sign[1]), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(tb_rsp_ready[1]), .r1_sum(r1_sum), .r1_ovf(r1_ovf),
        .busy(busy), .owner(owner), .dbg_state(dbg_state)
    );

    assign w_ready = {r1_ready, r0_ready};
    assign w_rsp   = {r1_rsp_valid, r0_rsp_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                             input logic sign, output logic [15:0] sum, output logic ovf);
        int ua, ub, r, sa, sb, rs;
        ua  = int'(a);
        ub  = int'(b);
        r   = sub ? ua - ub : ua + ub;
        sum = 16'(r);
        sa  = a[15] ? ua - 65536 : ua;
        sb  = b[15] ? ub - 65536 : ub;
        rs  = sub ? sa - sb : sa + sb;
        if (sign) ovf = (rs > 32767) || (rs < -32768);
        else      ovf = sub ? (ua >= ub) : (r > 65535);
    endtask

    function automatic logic [1:0] onehot(input int id);
        return (id == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One full transaction, entered and left just after a rising edge with the DUT idle.
    task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sign, input int hold, input bit raise_other);
        logic [15:0] es;
        logic        eo;
        int          oth;
        oth = 1 - id;
        ref_model(a, b, sub, sign, es, eo);
        tb_a[id] = a; tb_b[id] = b; tb_sub[id] = sub; tb_sign[id] = sign;
        tb_valid[id] = 1'b1;
        tb_rsp_ready[id] = (hold == 0);
        @(negedge clk);
        check("acc_ready", 32'(w_ready[id]), 32'(1));
        check("acc_other_ready", 32'(w_ready[oth]), 32'(0));
        check("acc_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        tb_valid[id] = 1'b0;
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'(1));
        check("exec_rsp", 32'(w_rsp), 32'(0));
        check("exec_owner", 32'(owner), 32'(id));
        @(negedge clk);
        check("rsp_valid", 32'(w_rsp), 32'(onehot(id)));
        check("rsp_sum", 32'(id ? r1_sum : r0_sum), 32'(es));
        check("rsp_ovf", 32'(id ? r1_ovf : r0_ovf), 32'(eo));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (raise_other && k == 0) begin
                tb_a[oth] = pend_a; tb_b[oth] = pend_b;
                tb_sub[oth] = pend_sub; tb_sign[oth] = pend_sign;
                tb_valid[oth] = 1'b1;
            end
            @(negedge clk);
            check("hold_rsp_valid", 32'(w_rsp), 32'(onehot(id)));
            check("hold_sum", 32'(r0_sum), 32'(es));
            check("hold_ovf", 32'(r0_ovf), 32'(eo));
            check("hold_ready", 32'(w_ready), 32'(0));
            check("hold_busy", 32'(busy), 32'(1));
        end
        tb_rsp_ready[id] = 1'b1;
        @(posedge clk); #1;
        tb_rsp_ready[id] = 1'b0;
        exp_ptr = (id == 0);
    endtask

    // Both requesters raise valid together; the pointer decides who goes first.
    task automatic serve_both();
        logic [15:0] a [2];
        logic [15:0] b [2];
        logic [1:0]  s, g;
        int          w;
        for (int i = 0; i < 2; i++) begin
            a[i] = rnd16(); b[i] = rnd16();
            tb_a[i] = a[i]; tb_b[i] = b[i];
        end
        s = 2'($urandom_range(0, 3));
        g = 2'($urandom_range(0, 3));
        tb_sub = s; tb_sign = g;
        tb_valid = 2'b11;
        w = int'(exp_ptr);
        do_op(w, a[w], b[w], s[w], g[w], int'($urandom_range(0, 3)), 1'b0);
        do_op(1 - w, a[1-w], b[1-w], s[1-w], g[1-w], int'($urandom_range(0, 3)), 1'b0);
    endtask

    initial begin
        int          last, acc, cyc, win;
        logic [15:0] alt_sum [2];
        logic        alt_ovf [2];

        n_checks = 0; n_errors = 0; exp_ptr = 1'b0;
        rst_n = 1'b0; tb_valid = '0; tb_sub = '0; tb_sign = '0; tb_rsp_ready = '0;
        tb_a[0] = '0; tb_a[1] = '0; tb_b[0] = '0; tb_b[1] = '0;
        pend_a = '0; pend_b = '0; pend_sub = 1'b0; pend_sign = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp", 32'(w_rsp), 32'(0));
        check("rst_ready", 32'(w_ready), 32'(0));
        check("rst_owner", 32'(owner), 32'(0));
        check("rst_sum", 32'(r0_sum), 32'(0));
        check("rst_ovf", 32'(r0_ovf), 32'(0));
        @(posedge clk); #1;

        // Directed arithmetic cases.
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(1, 16'h0005, 16'h0007, 1'b1, 1'b0, 1, 1'b0);
        do_op(1, 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
        do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0);
        do_op(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 2, 1'b0);

        // Backpressure with the other requester arriving during RESP.
        pend_a = 16'h0005; pend_b = 16'h0007; pend_sub = 1'b1; pend_sign = 1'b1;
        do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 5, 1'b1);
        do_op(1, pend_a, pend_b, pend_sub, pend_sign, 0, 1'b0);

        // Randomized traffic, single and contended.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                serve_both();
            end else begin
                do_op(int'($urandom_range(0, 1)), rnd16(), rnd16(), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
            end
        end

        // Reset during EXEC aborts the operation and restores the pointer.
        do_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 0, 1'b0);
        tb_a[1] = 16'h0F0F; tb_b[1] = 16'h0101; tb_sub[1] = 1'b0; tb_sign[1] = 1'b0;
        tb_valid[1] = 1'b1; tb_rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("abort_acc", 32'(w_ready), 32'(2'b10));
        @(posedge clk); #1;
        rst_n = 1'b0; tb_valid[1] = 1'b0;
        @(negedge clk);
        check("abort_exec_busy", 32'(busy), 32'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_owner", 32'(owner), 32'(0));
        check("abort_sum", 32'(r0_sum), 32'(0));
        check("abort_ovf", 32'(r0_ovf), 32'(0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(w_rsp), 32'(0));
        end
        tb_rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        exp_ptr = 1'b0;
        serve_both();

        // Both valid from reset with responses always taken: strict alternation every 3 cycles.
        tb_a[0] = 16'h1234; tb_b[0] = 16'h0101; tb_sub[0] = 1'b0; tb_sign[0] = 1'b0;
        tb_a[1] = 16'h8000; tb_b[1] = 16'h0001; tb_sub[1] = 1'b1; tb_sign[1] = 1'b1;
        ref_model(tb_a[0], tb_b[0], tb_sub[0], tb_sign[0], alt_sum[0], alt_ovf[0]);
        ref_model(tb_a[1], tb_b[1], tb_sub[1], tb_sign[1], alt_sum[1], alt_ovf[1]);
        tb_valid = 2'b11; tb_rsp_ready = 2'b11;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ptr = 1'b0;
        last = -1; acc = 0; cyc = 0; win = 0;
        while (acc < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (w_rsp != 2'b00) begin
                check("alt_rsp_owner", 32'(w_rsp), 32'(onehot(win)));
                check("alt_rsp_sum", 32'(win ? r1_sum : r0_sum), 32'(alt_sum[win]));
                check("alt_rsp_ovf", 32'(win ? r1_ovf : r0_ovf), 32'(alt_ovf[win]));
            end
            if (w_ready != 2'b00) begin
                check("alt_grant", 32'(w_ready), 32'(onehot(int'(exp_ptr))));
                if (last >= 0) check("alt_spacing", 32'(cyc - last), 32'(3));
                last = cyc;
                win = int'(exp_ptr);
                exp_ptr = ~exp_ptr;
                acc++;
            end
        end
        check("alt_done", 32'(acc), 32'(6));
        tb_valid = 2'b00;
        rst_n = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
